// File: rtl/divisor_sum_classifier_if.sv
// divisor_sum_classifier_if: start/operand handshake and classification results
interface divisor_sum_classifier_if #(
    parameter int W  = 16,
    parameter int SW = W + 3
);
    logic          go;
    logic [W-1:0]  N;
    logic          busy;
    logic          over;
    logic          IsPer;
    logic          abundant;
    logic          deficient;
    logic          invalid;
    logic [SW-1:0] sum;
    modport master (output go, N, input busy, over, IsPer, abundant, deficient, invalid, sum);
    modport slave  (input go, N, output busy, over, IsPer, abundant, deficient, invalid, sum);
endinterface

// File: rtl/divisor_sum_classifier.sv
// divisor_sum_classifier: sums proper divisors of N by trial division and classifies N
module divisor_sum_classifier #(
    parameter int W  = 16,
    parameter int SW = W + 3
) (
    input  logic                  clk,
    input  logic                  rst,
    divisor_sum_classifier_if.slave io
);
    localparam int CW = $clog2(W);
    typedef enum logic [2:0] {IDLE, INIT, TEST, DIV, ACC, FIN, DONE} state_t;
    state_t        st, nxt;
    logic [W-1:0]  nreg, d, dv, rem, quo, rem_nx;
    logic [CW-1:0] cnt;
    logic [SW-1:0] acc, sum;
    logic [W:0]    r;
    logic          ge, past, is_per, abundant, deficient, invalid;
    assign past   = d > (nreg >> 1);
    assign r      = {rem, quo[W-1]};
    assign ge     = r >= {1'b0, dv};
    assign rem_nx = ge ? r[W-1:0] - dv : r[W-1:0];
    assign io.busy      = st inside {INIT, TEST, DIV, ACC, FIN};
    assign io.over      = st == DONE;
    assign io.sum       = sum;
    assign io.IsPer     = is_per;
    assign io.abundant  = abundant;
    assign io.deficient = deficient;
    assign io.invalid   = invalid;
    // state register; reset aborts any operation at once
    always_ff @(posedge clk or negedge rst)
        if (!rst) st <= IDLE;
        else      st <= nxt;
    // next state: one trial divisor per TEST/DIV*W/ACC round
    always_comb begin
        nxt = st;
        case (st)
            IDLE, DONE: nxt = io.go ? INIT : st;
            INIT:       nxt = TEST;
            TEST:       nxt = past ? FIN : DIV;
            DIV:        nxt = cnt == CW'(W - 1) ? ACC : DIV;
            ACC:        nxt = TEST;
            FIN:        nxt = DONE;
            default:    nxt = IDLE;
        endcase
    end
    // datapath: operand latch, restoring divider, accumulator and result registers
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            nreg      <= '0;
            d         <= '0;
            dv        <= '0;
            rem       <= '0;
            quo       <= '0;
            cnt       <= '0;
            acc       <= '0;
            sum       <= '0;
            is_per    <= 1'b0;
            abundant  <= 1'b0;
            deficient <= 1'b0;
            invalid   <= 1'b0;
        end else begin
            case (st)
                IDLE, DONE: if (io.go) nreg <= io.N;
                INIT: begin
                    d   <= W'(1);
                    acc <= '0;
                end
                TEST: if (!past) begin
                    rem <= '0;
                    quo <= nreg;
                    dv  <= d;
                    cnt <= '0;
                end
                DIV: begin
                    rem <= rem_nx;
                    quo <= {quo[W-2:0], ge};
                    cnt <= cnt + 1'b1;
                end
                ACC: begin
                    if (rem == '0) acc <= acc + SW'(d);
                    d <= d + 1'b1;
                end
                FIN: begin
                    sum       <= acc;
                    invalid   <= nreg == '0;
                    is_per    <= nreg != '0 && acc == SW'(nreg);
                    abundant  <= nreg != '0 && acc >  SW'(nreg);
                    deficient <= nreg != '0 && acc <  SW'(nreg);
                end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_divisor_sum_classifier.sv
// tb_divisor_sum_classifier: random and directed checks against a divisor-sum model
module tb_divisor_sum_classifier;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    divisor_sum_classifier_if #(.W(16)) ia ();
    divisor_sum_classifier_if #(.W(8))  ib ();
    divisor_sum_classifier #(.W(16)) da (.clk(clk), .rst(rst), .io(ia.slave));
    divisor_sum_classifier #(.W(8))  db (.clk(clk), .rst(rst), .io(ib.slave));
    typedef struct packed {
        logic [31:0] sum;
        logic        isper, ab, def, inv;
    } res_t;
    res_t prev [2];
    res_t cur  [2];
    int unsigned npass = 0, ntot = 0;
    task automatic cmp(input string nm, input logic [63:0] a, input logic [63:0] e);
        ntot++;
        if (a === e) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    endtask
    function automatic res_t model(input int unsigned n);
        res_t m;
        int unsigned s = 0;
        for (int unsigned i = 1; i <= n / 2; i++) if (n % i == 0) s += i;
        m.sum   = s;
        m.inv   = n == 0;
        m.isper = n != 0 && s == n;
        m.ab    = n != 0 && s > n;
        m.def   = n != 0 && s < n;
        return m;
    endfunction
    function automatic int unsigned lat(input int unsigned n, input int unsigned w);
        return (n / 2) * (w + 2) + 3;
    endfunction
    function automatic res_t act(input bit s);
        return s ? res_t'({32'(ib.sum), ib.IsPer, ib.abundant, ib.deficient, ib.invalid})
                 : res_t'({32'(ia.sum), ia.IsPer, ia.abundant, ia.deficient, ia.invalid});
    endfunction
    function automatic logic busy_of(input bit s);
        return s ? ib.busy : ia.busy;
    endfunction
    function automatic logic over_of(input bit s);
        return s ? ib.over : ia.over;
    endfunction
    task automatic set_in(input bit s, input logic g, input logic [31:0] n);
        if (s) begin
            ib.go = g;
            ib.N  = n[7:0];
        end else begin
            ia.go = g;
            ia.N  = n[15:0];
        end
    endtask
    // every cycle: busy holds the previous result, over presents the current one
    always @(negedge clk)
        if (rst)
            for (int s = 0; s < 2; s++) begin
                if (busy_of(s[0])) begin
                    cmp("held_result", 64'(act(s[0])), 64'(prev[s]));
                    cmp("over_while_busy", 64'(over_of(s[0])), 64'd0);
                end else if (over_of(s[0])) begin
                    cmp("result", 64'(act(s[0])), 64'(cur[s]));
                end
            end
    task automatic run(input bit s, input int unsigned n, input int rp, input int unsigned rpn,
                       input int abort_at, output int k);
        int unsigned l;
        l = lat(n, s ? 8 : 16);
        set_in(s, 1'b1, n);
        @(posedge clk);
        #1;
        set_in(s, 1'b0, $urandom);
        prev[s] = cur[s];
        cur[s]  = model(n);
        k = 0;
        forever begin
            @(posedge clk);
            #1;
            k++;
            if (k == abort_at) return;
            if (rp != 0 && k == rp - 1) set_in(s, 1'b1, rpn);
            if (rp != 0 && k == rp) set_in(s, 1'b0, $urandom);
            if (over_of(s)) break;
            if (k > int'(l) + 20) begin
                cmp("timeout", 64'(k), 64'(l));
                return;
            end
        end
        cmp("latency", 64'(k), 64'(l));
    endtask
    task automatic directed(input bit s, input int unsigned n, input int unsigned lsum,
                            input int unsigned llat, input logic [3:0] lcls,
                            input int rp = 0, input int unsigned rpn = 0);
        int k;
        res_t m, a;
        m = model(n);
        cmp("model_sum", 64'(m.sum), 64'(lsum));
        cmp("model_class", 64'({m.isper, m.ab, m.def, m.inv}), 64'(lcls));
        run(s, n, rp, rpn, 0, k);
        a = act(s);
        cmp("lit_latency", 64'(k), 64'(llat));
        cmp("lit_sum", 64'(a.sum), 64'(lsum));
        cmp("lit_class", 64'({a.isper, a.ab, a.def, a.inv}), 64'(lcls));
        cmp("busy_done", 64'(busy_of(s)), 64'd0);
    endtask
    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int k;
        int unsigned n;
        set_in(1'b0, 1'b0, 0);
        set_in(1'b1, 1'b0, 0);
        for (int s = 0; s < 2; s++) begin
            prev[s] = '0;
            cur[s]  = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            cmp("reset_busy", 64'(busy_of(s[0])), 64'd0);
            cmp("reset_over", 64'(over_of(s[0])), 64'd0);
            cmp("reset_result", 64'(act(s[0])), 64'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        directed(1'b0, 6, 6, 57, 4'b1000);
        directed(1'b0, 12, 16, 111, 4'b0100);
        directed(1'b0, 8, 7, 75, 4'b0010);
        run(1'b0, 28, 0, 0, 20, k);
        rst = 1'b0;
        #1;
        cmp("abort_busy", 64'(ia.busy), 64'd0);
        cmp("abort_over", 64'(ia.over), 64'd0);
        cmp("abort_result", 64'(act(1'b0)), 64'd0);
        for (int s = 0; s < 2; s++) begin
            prev[s] = '0;
            cur[s]  = '0;
        end
        @(negedge clk);
        rst = 1'b1;
        directed(1'b0, 28, 28, 255, 4'b1000);
        directed(1'b0, 1, 0, 3, 4'b0010);
        directed(1'b0, 0, 0, 3, 4'b0001);
        directed(1'b1, 240, 504, 1203, 4'b0100, 10, 6);
        repeat (8) begin
            n = $urandom_range(0, 80);
            run(1'b0, n, 0, 0, 0, k);
        end
        repeat (5) begin
            n = $urandom_range(0, 255);
            run(1'b1, n, 0, 0, 0, k);
        end
        directed(1'b0, 8128, 8128, 73155, 4'b1000);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
